// File: rtl/seq_multiplier_bcd_if.sv
// Operand/result bundle for seq_multiplier_bcd.
// The master side supplies operands and the start request; the slave side
// (the multiplier) returns the registered product, sign flag, BCD digits and
// the busy/finish status.
interface seq_multiplier_bcd_if #(
    parameter int N = 8
) ();
    localparam int DIGITS = (2 * N) / 3 + 1;

    logic                  start_i;
    logic                  signed_mode_i;
    logic [N-1:0]          a_i;
    logic [N-1:0]          b_i;
    logic [2*N-1:0]        out_o;
    logic                  neg_o;
    logic [4*DIGITS-1:0]   bcd_o;
    logic                  busy_o;
    logic                  finish_o;

    modport master (
        output start_i, signed_mode_i, a_i, b_i,
        input  out_o, neg_o, bcd_o, busy_o, finish_o
    );

    modport slave (
        input  start_i, signed_mode_i, a_i, b_i,
        output out_o, neg_o, bcd_o, busy_o, finish_o
    );
endinterface

// File: rtl/seq_multiplier_bcd.sv
// Sequential shift-add multiplier with built-in double-dabble BCD conversion.
// Operands are captured as magnitudes plus a sign bit; the magnitude product
// is formed over N cycles, converted to BCD over 2N cycles, and the result
// (two's complement product, sign flag, BCD of the magnitude) is committed to
// the output registers from the DONE state. Outputs hold until the next
// commit, so intermediate values never appear on the ports.
module seq_multiplier_bcd #(
    parameter int N = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    seq_multiplier_bcd_if.slave bus
);
    localparam int DIGITS = (2 * N) / 3 + 1;
    localparam int W      = 2 * N;
    localparam int CW     = $clog2(W + 1);
    localparam int BW     = 4 * DIGITS;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        CONV = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            sign_q, sign_d;
    logic [W-1:0]    mcand_q, mcand_d;   // multiplicand magnitude, shifted left each step
    logic [N-1:0]    mplier_q, mplier_d; // multiplier magnitude, shifted right each step
    logic [W-1:0]    acc_q, acc_d;       // magnitude product
    logic [W-1:0]    bin_q, bin_d;       // binary bits still to be shifted into the digits
    logic [BW-1:0]   dig_q, dig_d;       // BCD digits under construction

    logic [W-1:0]    out_q, out_d;
    logic            neg_q, neg_d;
    logic [BW-1:0]   bcd_q, bcd_d;
    logic            busy_q, busy_d;
    logic            finish_q, finish_d;

    logic [N-1:0]    a_mag;
    logic [N-1:0]    b_mag;
    logic            op_sign;
    logic [W-1:0]    acc_step;
    logic [BW-1:0]   dig_adj;
    logic [BW+W-1:0] dd_shifted;
    logic            prod_nonzero;

    // In signed mode the most negative value negates to 2^(N-1), which still
    // fits the N-bit unsigned magnitude.
    assign a_mag   = (bus.signed_mode_i && bus.a_i[N-1]) ? (~bus.a_i + {{(N-1){1'b0}}, 1'b1}) : bus.a_i;
    assign b_mag   = (bus.signed_mode_i && bus.b_i[N-1]) ? (~bus.b_i + {{(N-1){1'b0}}, 1'b1}) : bus.b_i;
    assign op_sign = bus.signed_mode_i & (bus.a_i[N-1] ^ bus.b_i[N-1]);

    // One radix-2 step: add the shifted multiplicand when the current
    // multiplier bit is set.
    assign acc_step = acc_q + (mplier_q[0] ? mcand_q : {W{1'b0}});

    // Double-dabble correction: every digit that is 5 or more gets +3 so that
    // the following left shift carries correctly into the next digit.
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_dd_adjust
        assign dig_adj[4*gi +: 4] = (dig_q[4*gi +: 4] >= 4'd5) ? (dig_q[4*gi +: 4] + 4'd3)
                                                               : dig_q[4*gi +: 4];
    end

    // Digits and remaining binary bits shift left together as one register.
    assign dd_shifted   = {dig_adj, bin_q} << 1;
    assign prod_nonzero = |acc_q;

    // Next-state and datapath decisions; every register holds by default.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sign_d   = sign_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        bin_d    = bin_q;
        dig_d    = dig_q;
        out_d    = out_q;
        neg_d    = neg_q;
        bcd_d    = bcd_q;
        busy_d   = busy_q;
        finish_d = 1'b0;

        case (state_q)
            IDLE: begin
                // busy covers the cycle after DONE (where finish is shown)
                // and drops on the next edge unless a new operation starts.
                busy_d = 1'b0;
                if (bus.start_i) begin
                    state_d  = MULT;
                    cnt_d    = '0;
                    sign_d   = op_sign;
                    mcand_d  = {{N{1'b0}}, a_mag};
                    mplier_d = b_mag;
                    acc_d    = '0;
                    busy_d   = 1'b1;
                end
            end

            MULT: begin
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    // Final product goes straight into the conversion shifter.
                    state_d = CONV;
                    cnt_d   = '0;
                    bin_d   = acc_step;
                    dig_d   = '0;
                end
            end

            CONV: begin
                {dig_d, bin_d} = dd_shifted;
                cnt_d          = cnt_q + CW'(1);
                if (cnt_q == CW'(W - 1)) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end
            end

            DONE: begin
                // Commit the result; a zero product is never reported negative.
                state_d  = IDLE;
                finish_d = 1'b1;
                busy_d   = 1'b1;
                neg_d    = sign_q & prod_nonzero;
                out_d    = (sign_q && prod_nonzero) ? (~acc_q + {{(W-1){1'b0}}, 1'b1}) : acc_q;
                bcd_d    = dig_q;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            sign_q   <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            bin_q    <= '0;
            dig_q    <= '0;
            out_q    <= '0;
            neg_q    <= 1'b0;
            bcd_q    <= '0;
            busy_q   <= 1'b0;
            finish_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sign_q   <= sign_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            bin_q    <= bin_d;
            dig_q    <= dig_d;
            out_q    <= out_d;
            neg_q    <= neg_d;
            bcd_q    <= bcd_d;
            busy_q   <= busy_d;
            finish_q <= finish_d;
        end
    end

    assign bus.out_o    = out_q;
    assign bus.neg_o    = neg_q;
    assign bus.bcd_o    = bcd_q;
    assign bus.busy_o   = busy_q;
    assign bus.finish_o = finish_q;
endmodule

// File: doc/seq_multiplier_bcd.md
# seq_multiplier_bcd

Parametrised sequential shift-add multiplier with an integrated double-dabble binary-to-BCD converter. It is the next generation of the team's N-bit multiplier. It adds per-operation signed/unsigned mode, a sign flag with a BCD magnitude, a busy indication, and defined back-to-back operation. It sits between operand capture logic and display/readout logic that consumes BCD digits.

## Interface
- N, default 8: operand width in bits, N >= 2.
- DIGITS, default (2*N)/3+1: number of BCD digits, derived, not overridden.
- clk  input  1  rising-edge clock; the only clock.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  level request, sampled only in IDLE.
- signed_mode  input  1  1 = operands are two's complement; 0 = unsigned.
- a_in  input  N  multiplicand.
- b_in  input  N  multiplier.
- out  output  2N  product: two's complement when signed_mode, else unsigned.
- neg  output  1  product is negative (signed_mode only; never set for zero).
- bcd  output  4*DIGITS  BCD of |product|, least-significant digit in bits [3:0].
- busy  output  1  an operation is in progress.
- finish  output  1  one-cycle completion pulse.

## Operation
- FSM states: IDLE, MULT, CONV, DONE.
- IDLE:
  - When start=1 at a rising edge, latch a_in, b_in and signed_mode, then go to MULT.
  - When start=0, stay in IDLE.
- Operand capture: in signed mode, convert each operand to its N-bit magnitude and record sign = a[N-1] XOR b[N-1]. -2^(N-1) has magnitude 2^(N-1), which fits in N unsigned bits.
- MULT: radix-2 shift-add over the magnitudes for exactly N cycles. The 2N-bit accumulator cannot overflow (max magnitude (2^N-1)^2).
- End of MULT: if sign=1 and the magnitude is nonzero, out = two's complement of the magnitude and neg=1. Otherwise out = magnitude and neg=0.
- CONV: double-dabble on the magnitude for exactly 2N cycles. Before each shift, add 3 to every digit >= 5. Conversion always uses the magnitude, never the two's complement value.
- DONE: lasts one cycle. finish=1; bcd, out and neg are updated to the new result. Then go to IDLE.
- Output holding: out, neg and bcd hold their values until the next DONE. They are not cleared when a new operation starts. Intermediate values never appear on these ports.
- Input handling:
  - start is ignored outside IDLE.
  - Changes on a_in, b_in and signed_mode after capture have no effect.
- Level start: if start stays high, the next operation is accepted on the edge after DONE. There is exactly one IDLE cycle between operations.

## Timing
- Reset (async assert, sync-safe release): state=IDLE, out=0, neg=0, bcd=0, busy=0, finish=0, internal registers = 0.
- Reset asserted mid-operation aborts immediately. No finish pulse is produced for the aborted operation.
- Counting from the start-capture edge E0:
  - busy=1 from E0 through the DONE cycle, inclusive.
  - finish=1 for the single cycle after edge E0+3N+1.
  - Total latency is 3N+1 cycles (16 cycles for N=5).
- busy falls at the same edge where finish falls.
- Back-to-back with start held high: the next capture occurs on the edge after DONE, so the period is 3N+2 cycles.
- No combinational path from any input to any output; all outputs are registered.

## Test plan
- Reset: hold reset=0 during activity, then release. Required: all outputs 0, busy=0. Assert reset mid-MULT. Required: outputs go to 0 immediately and no finish pulse follows.
- N=5, unsigned, a=26, b=30, start pulse. Required: finish 16 cycles after capture; out=10'h30C (780), bcd=16'h0780, neg=0.
- N=5, signed:
  - a=5'd26 (-6), b=5'd30 (-2). Required: out=10'h00C, bcd=16'h0012, neg=0.
  - a=13, b=5'd29 (-3). Required: out=10'h3D9, bcd=16'h0039, neg=1.
- N=5 boundaries:
  - Unsigned 31*31. Required: out=10'h3C1, bcd=16'h0961.
  - Signed 16*16 (-16 * -16). Required: out=10'h100, bcd=16'h0256, neg=0.
  - Signed 0*29. Required: out=0, neg=0, bcd=0.
- Handshake:
  - Hold start=1 with a=13, b=13 unsigned. Required: consecutive finish pulses 17 cycles apart, each with out=10'h0A9 and bcd=16'h0169.
  - Toggle a_in and start while busy. Required: no effect on the in-flight result.
- N=8 default, unsigned 255*255. Required: out=16'hFE01, bcd=24'h065025, latency 25 cycles.
